// File: rtl/tristate_pkg.sv
// Shared definitions for the registered tristate-net bus model.
// Contents:
//   - contention-handling mode encodings;
//   - enable-count classification;
//   - owner-index width helper.
package tristate_pkg;

    localparam int unsigned TRI_MODE_POISON   = 0;
    localparam int unsigned TRI_MODE_PRIORITY = 1;

    // How many drivers asserted their enable in a given cycle
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ONE  = 2'd1,
        CLS_MANY = 2'd2
    } en_class_t;

    // Owner index width; never narrower than one bit
    function automatic int unsigned owner_w(input int unsigned n);
        return (n < 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/tristate_resolve.sv
// Combinational driver resolver: classifies the enable count and picks
// the lowest-index enabled driver together with its data.
// Ports:
//   i_noe       active-low enables, a bit is enabled only when exactly 0
//   i_data      packed driver data, driver k at [WIDTH*(k+1)-1 -: WIDTH]
//   cls_c       none / one / many enabled
//   win_idx_c   lowest enabled index (0 when none)
//   win_data_c  data of that driver (0 when none)
module tristate_resolve
    import tristate_pkg::*;
#(
    parameter int unsigned INPUT_COUNT = 2,
    parameter int unsigned WIDTH       = 8
) (
    input  logic [INPUT_COUNT-1:0]               i_noe,
    input  logic [WIDTH*INPUT_COUNT-1:0]         i_data,
    output en_class_t                            cls_c,
    output logic [owner_w(INPUT_COUNT)-1:0]      win_idx_c,
    output logic [WIDTH-1:0]                     win_data_c
);

    localparam int unsigned OWN_W = owner_w(INPUT_COUNT);

    logic [INPUT_COUNT-1:0] en;
    logic                   seen_one;
    logic                   seen_many;

    // X or Z on an enable is treated as disabled
    always_comb begin
        en = '0;
        for (int k = 0; k < int'(INPUT_COUNT); k++) begin
            en[k] = (i_noe[k] === 1'b0);
        end
    end

    // Count class and lowest-index winner
    always_comb begin
        seen_one   = 1'b0;
        seen_many  = 1'b0;
        win_idx_c  = '0;
        win_data_c = '0;
        cls_c      = CLS_NONE;
        for (int k = 0; k < int'(INPUT_COUNT); k++) begin
            if (en[k]) begin
                if (seen_one) begin
                    seen_many = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
        // Walk downwards so the lowest enabled index is written last
        for (int k = int'(INPUT_COUNT) - 1; k >= 0; k--) begin
            if (en[k]) begin
                win_idx_c  = OWN_W'(k);
                win_data_c = i_data[WIDTH*k +: WIDTH];
            end
        end
        if (seen_many) begin
            cls_c = CLS_MANY;
        end else if (seen_one) begin
            cls_c = CLS_ONE;
        end
    end

endmodule

// File: rtl/tristatenet_reg.sv
// Registered tristate bus: resolves INPUT_COUNT active-low-enabled drivers
// onto one WIDTH-bit bus with one cycle of latency, tracks the owning
// driver and reports contention (pulse, sticky flag, saturating count).
// Optional feature macro: TRISTATE_KEEPER_EN
//   defined   - bus keeper, an undriven bus holds its last registered value
//   undefined - pull-up, an undriven bus reads all-ones
// Ports:
//   i_clk, i_nrst       clock, asynchronous active-low reset
//   i_data, i_noe       packed driver data and active-low enables
//   i_clr               synchronous clear of sticky flag and counter
//   o_data, o_noe       registered bus value and bus-valid (active low)
//   o_owner             index of the last driver that won the bus
//   o_conflict          one-cycle pulse per conflicting sample
//   o_conflict_sticky   latched conflict flag
//   o_conflict_cnt      saturating conflict cycle count
module tristatenet_reg
    import tristate_pkg::*;
#(
    parameter int unsigned INPUT_COUNT   = 2,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned CNT_WIDTH     = 8,
    parameter int unsigned PRIORITY_MODE = TRI_MODE_POISON
) (
    input  logic                              i_clk,
    input  logic                              i_nrst,
    input  logic [WIDTH*INPUT_COUNT-1:0]      i_data,
    input  logic [INPUT_COUNT-1:0]            i_noe,
    input  logic                              i_clr,
    output logic [WIDTH-1:0]                  o_data,
    output logic                              o_noe,
    output logic [owner_w(INPUT_COUNT)-1:0]   o_owner,
    output logic                              o_conflict,
    output logic                              o_conflict_sticky,
    output logic [CNT_WIDTH-1:0]              o_conflict_cnt
);

    localparam int unsigned OWN_W = owner_w(INPUT_COUNT);

    en_class_t              cls;
    logic [OWN_W-1:0]       win_idx;
    logic [WIDTH-1:0]       win_data;

    logic [WIDTH-1:0]       data_n;
    logic                   noe_n;
    logic [OWN_W-1:0]       owner_n;
    logic                   conflict_n;
    logic                   sticky_n;
    logic [CNT_WIDTH-1:0]   cnt_n;
    logic [CNT_WIDTH-1:0]   cnt_base;

    tristate_resolve #(
        .INPUT_COUNT (INPUT_COUNT),
        .WIDTH       (WIDTH)
    ) u_resolve (
        .i_noe      (i_noe),
        .i_data     (i_data),
        .cls_c      (cls),
        .win_idx_c  (win_idx),
        .win_data_c (win_data)
    );

    // Next-state for bus value, ownership and diagnostics
    always_comb begin
`ifdef TRISTATE_KEEPER_EN
        data_n = o_data;
`else
        data_n = '1;
`endif
        noe_n      = 1'b1;
        owner_n    = o_owner;
        conflict_n = 1'b0;
        // Clear is applied first so a coincident conflict lands on top of it
        cnt_base   = i_clr ? '0 : o_conflict_cnt;
        sticky_n   = i_clr ? 1'b0 : o_conflict_sticky;
        cnt_n      = cnt_base;
        case (cls)
            CLS_ONE: begin
                data_n  = win_data;
                noe_n   = 1'b0;
                owner_n = win_idx;
            end
            CLS_MANY: begin
                conflict_n = 1'b1;
                sticky_n   = 1'b1;
                cnt_n      = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
                if (PRIORITY_MODE == TRI_MODE_PRIORITY) begin
                    data_n  = win_data;
                    noe_n   = 1'b0;
                    owner_n = win_idx;
                end else begin
`ifdef SYNTHESIS
                    data_n = o_data;
`else
                    data_n = {WIDTH{1'bx}};
`endif
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_data            <= '1;
            o_noe             <= 1'b1;
            o_owner           <= '0;
            o_conflict        <= 1'b0;
            o_conflict_sticky <= 1'b0;
            o_conflict_cnt    <= '0;
        end else begin
            o_data            <= data_n;
            o_noe             <= noe_n;
            o_owner           <= owner_n;
            o_conflict        <= conflict_n;
            o_conflict_sticky <= sticky_n;
            o_conflict_cnt    <= cnt_n;
        end
    end

`ifndef SYNTHESIS
    // Report unresolved contention in simulation
    always @(posedge i_clk) begin
        if (i_nrst && (PRIORITY_MODE != TRI_MODE_PRIORITY) && (cls == CLS_MANY)) begin
            $display("%m: bus contention, poisoned bus at time %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_tristatenet_reg.sv
// Directed bench for tristatenet_reg: three instances share the stimulus
// (poison mode, priority mode, and a 2-bit counter for saturation).
module tb_tristatenet_reg;

    logic        clk;
    logic        nrst;
    logic [31:0] data;
    logic [3:0]  noe;
    logic        clr;

    logic [7:0] p0_data, p1_data, ps_data;
    logic       p0_noe, p1_noe, ps_noe;
    logic [1:0] p0_owner, p1_owner, ps_owner;
    logic       p0_conf, p1_conf, ps_conf;
    logic       p0_sticky, p1_sticky, ps_sticky;
    logic [7:0] p0_cnt, p1_cnt;
    logic [1:0] ps_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    tristatenet_reg #(.INPUT_COUNT(4), .WIDTH(8), .CNT_WIDTH(8), .PRIORITY_MODE(0)) u_p0 (
        .i_clk(clk), .i_nrst(nrst), .i_data(data), .i_noe(noe), .i_clr(clr),
        .o_data(p0_data), .o_noe(p0_noe), .o_owner(p0_owner), .o_conflict(p0_conf),
        .o_conflict_sticky(p0_sticky), .o_conflict_cnt(p0_cnt)
    );

    tristatenet_reg #(.INPUT_COUNT(4), .WIDTH(8), .CNT_WIDTH(8), .PRIORITY_MODE(1)) u_p1 (
        .i_clk(clk), .i_nrst(nrst), .i_data(data), .i_noe(noe), .i_clr(clr),
        .o_data(p1_data), .o_noe(p1_noe), .o_owner(p1_owner), .o_conflict(p1_conf),
        .o_conflict_sticky(p1_sticky), .o_conflict_cnt(p1_cnt)
    );

    tristatenet_reg #(.INPUT_COUNT(4), .WIDTH(8), .CNT_WIDTH(2), .PRIORITY_MODE(0)) u_sat (
        .i_clk(clk), .i_nrst(nrst), .i_data(data), .i_noe(noe), .i_clr(clr),
        .o_data(ps_data), .o_noe(ps_noe), .o_owner(ps_owner), .o_conflict(ps_conf),
        .o_conflict_sticky(ps_sticky), .o_conflict_cnt(ps_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nrst = 1'b0; noe = 4'hF; data = '0; clr = 1'b0;
        #12;
        tests_run++;
        if ({p0_data, p0_noe, p0_owner, p0_conf, p0_sticky, p0_cnt} !== {8'hFF, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_p0: got %h/%b/%0d/%b/%b/%0d want FF/1/0/0/0/0", p0_data, p0_noe, p0_owner, p0_conf, p0_sticky, p0_cnt);
        end
        tests_run++;
        if ({ps_sticky, ps_cnt} !== {1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_sat: got sticky=%b cnt=%0d want 0/0", ps_sticky, ps_cnt);
        end
        nrst = 1'b1;
        step();
        tests_run++;
        if ({p0_data, p0_noe, p0_owner, p0_conf} !== {8'hFF, 1'b1, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %h/%b/%0d/%b want FF/1/0/0", p0_data, p0_noe, p0_owner, p0_conf);
        end
    endtask

    task automatic test_single;
        data = {8'h00, 8'h00, 8'h3C, 8'h00}; noe = 4'b1101;
        step();
        tests_run++;
        if ({p0_data, p0_noe, p0_owner, p0_conf} !== {8'h3C, 1'b0, 2'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_p0: got %h/%b/%0d/%b want 3C/0/1/0", p0_data, p0_noe, p0_owner, p0_conf);
        end
        tests_run++;
        if ({p1_data, p1_noe, p1_owner} !== {8'h3C, 1'b0, 2'd1}) begin
            tests_failed++;
            $display("FAIL single_p1: got %h/%b/%0d want 3C/0/1", p1_data, p1_noe, p1_owner);
        end
    endtask

    task automatic test_conflict_poison;
        data = {8'h00, 8'h00, 8'h33, 8'h22}; noe = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({p0_noe, p0_owner, p0_conf} !== {1'b1, 2'd1, 1'b1}) begin
                tests_failed++;
                $display("FAIL poison_cycle%0d: got noe=%b owner=%0d conf=%b want 1/1/1", i, p0_noe, p0_owner, p0_conf);
            end
            tests_run++;
            if ({p1_data, p1_noe, p1_owner, p1_conf} !== {8'h22, 1'b0, 2'd0, 1'b1}) begin
                tests_failed++;
                $display("FAIL prio_cycle%0d: got %h/%b/%0d/%b want 22/0/0/1", i, p1_data, p1_noe, p1_owner, p1_conf);
            end
        end
        tests_run++;
        if ({p0_sticky, p0_cnt, ps_cnt} !== {1'b1, 8'd3, 2'd3}) begin
            tests_failed++;
            $display("FAIL poison_count: got sticky=%b cnt=%0d satcnt=%0d want 1/3/3", p0_sticky, p0_cnt, ps_cnt);
        end
        noe = 4'hF;
        step();
        tests_run++;
        if ({p0_noe, p0_owner, p0_conf, p0_sticky, p0_cnt} !== {1'b1, 2'd1, 1'b0, 1'b1, 8'd3}) begin
            tests_failed++;
            $display("FAIL poison_after: got noe=%b owner=%0d conf=%b sticky=%b cnt=%0d want 1/1/0/1/3", p0_noe, p0_owner, p0_conf, p0_sticky, p0_cnt);
        end
    endtask

    task automatic test_conflict_priority;
        data = {8'h99, 8'h00, 8'h00, 8'h11}; noe = 4'b0110;
        step();
        tests_run++;
        if ({p1_data, p1_noe, p1_owner, p1_conf, p1_sticky, p1_cnt} !== {8'h11, 1'b0, 2'd0, 1'b1, 1'b1, 8'd4}) begin
            tests_failed++;
            $display("FAIL prio_0110: got %h/%b/%0d/%b/%b/%0d want 11/0/0/1/1/4", p1_data, p1_noe, p1_owner, p1_conf, p1_sticky, p1_cnt);
        end
        tests_run++;
        if ({p0_noe, p0_cnt, ps_cnt} !== {1'b1, 8'd4, 2'd3}) begin
            tests_failed++;
            $display("FAIL poison_0110: got noe=%b cnt=%0d satcnt=%0d want 1/4/3", p0_noe, p0_cnt, ps_cnt);
        end
    endtask

    task automatic test_keeper;
        logic [7:0] idle_exp;
`ifdef TRISTATE_KEEPER_EN
        idle_exp = 8'hA5;
`else
        idle_exp = 8'hFF;
`endif
        data = {8'h00, 8'hA5, 8'h00, 8'h00}; noe = 4'b1011;
        step();
        tests_run++;
        if ({p0_data, p0_noe, p0_owner} !== {8'hA5, 1'b0, 2'd2}) begin
            tests_failed++;
            $display("FAIL keeper_drive: got %h/%b/%0d want A5/0/2", p0_data, p0_noe, p0_owner);
        end
        noe = 4'hF;
        step();
        tests_run++;
        if ({p0_data, p0_noe, p0_owner} !== {idle_exp, 1'b1, 2'd2}) begin
            tests_failed++;
            $display("FAIL keeper_idle: got %h/%b/%0d want %h/1/2", p0_data, p0_noe, p0_owner, idle_exp);
        end
        tests_run++;
        if ({p1_data, p1_noe, p1_owner} !== {idle_exp, 1'b1, 2'd2}) begin
            tests_failed++;
            $display("FAIL keeper_idle_p1: got %h/%b/%0d want %h/1/2", p1_data, p1_noe, p1_owner, idle_exp);
        end
    endtask

    task automatic test_clear_saturate;
        clr = 1'b1; noe = 4'hF;
        step();
        tests_run++;
        if ({ps_sticky, ps_cnt, p0_sticky, p0_cnt} !== {1'b0, 2'd0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL clear_first: got sat %b/%0d p0 %b/%0d want 0/0 0/0", ps_sticky, ps_cnt, p0_sticky, p0_cnt);
        end
        clr = 1'b0; noe = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if ({ps_cnt, p0_cnt} !== {((i < 2) ? 2'(i + 1) : 2'd3), 8'(i + 1)}) begin
                tests_failed++;
                $display("FAIL saturate_cycle%0d: got satcnt=%0d p0cnt=%0d want %0d/%0d", i, ps_cnt, p0_cnt, (i < 2) ? i + 1 : 3, i + 1);
            end
        end
        clr = 1'b1;
        step();
        tests_run++;
        if ({ps_conf, ps_sticky, ps_cnt, p0_cnt} !== {1'b1, 1'b1, 2'd1, 8'd1}) begin
            tests_failed++;
            $display("FAIL clear_with_conflict: got conf=%b sticky=%b satcnt=%0d p0cnt=%0d want 1/1/1/1", ps_conf, ps_sticky, ps_cnt, p0_cnt);
        end
        noe = 4'hF;
        step();
        tests_run++;
        if ({ps_conf, ps_sticky, ps_cnt, p0_sticky, p0_cnt} !== {1'b0, 1'b0, 2'd0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL clear_alone: got conf=%b sticky=%b satcnt=%0d p0 %b/%0d want 0/0/0 0/0", ps_conf, ps_sticky, ps_cnt, p0_sticky, p0_cnt);
        end
        clr = 1'b0;
    endtask

    task automatic test_async_reset;
        data = {8'h00, 8'h00, 8'h00, 8'h00}; noe = 4'b1100;
        step();
        tests_run++;
        if ({p0_sticky, p0_cnt, p0_owner} !== {1'b1, 8'd1, 2'd2}) begin
            tests_failed++;
            $display("FAIL pre_reset: got sticky=%b cnt=%0d owner=%0d want 1/1/2", p0_sticky, p0_cnt, p0_owner);
        end
        #2 nrst = 1'b0;
        #1;
        tests_run++;
        if ({p0_data, p0_noe, p0_owner, p0_conf, p0_sticky, p0_cnt} !== {8'hFF, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL async_reset_p0: got %h/%b/%0d/%b/%b/%0d want FF/1/0/0/0/0", p0_data, p0_noe, p0_owner, p0_conf, p0_sticky, p0_cnt);
        end
        tests_run++;
        if ({p1_data, p1_noe, p1_owner, p1_conf} !== {8'hFF, 1'b1, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_reset_p1: got %h/%b/%0d/%b want FF/1/0/0", p1_data, p1_noe, p1_owner, p1_conf);
        end
        data = {8'h5A, 8'h00, 8'h00, 8'h00}; noe = 4'b0111;
        #1 nrst = 1'b1;
        step();
        tests_run++;
        if ({p0_data, p0_noe, p0_owner, p0_conf} !== {8'h5A, 1'b0, 2'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL first_edge: got %h/%b/%0d/%b want 5A/0/3/0", p0_data, p0_noe, p0_owner, p0_conf);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict_poison();
        test_conflict_priority();
        test_keeper();
        test_clear_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
